game_flow_ctrl: RTL
===================

# game_flow_ctrl

Top-level game sequencer for the volcano-flight game. It gates the per-pixel-clock collision result from the crash checker down to one evaluation per video frame and owns the lives counter. It grants a post-hit invulnerability window with sprite blinking, and drives the run/pause enable consumed by the plane, mountain and lava movers. It sits between the VGA frame-timing logic, the collision checker and the sprite/scroll datapath.

## Interface
Parameters:
- LIVES, 3: lives loaded at game start; 1..7.
- IFRAMES, 60: invulnerability length in frames after a non-fatal hit; ≥1.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame (vertical blank start).
- start  in  1  start button, level, already synchronised to clk.
- crash  in  1  raw collision flag, combinational, valid every cycle.
- life  out  3  remaining lives.
- state  out  2  FSM state: 0 IDLE, 1 PLAY, 2 HIT, 3 OVER.
- objects_run  out  1  enables movement of plane, mountains and lava.
- plane_visible  out  1  sprite enable for plane drawing.
- game_over  out  1  high in OVER.
- score  out  16  frames survived; present only with GAME_SCORE_EN.

## Operation
- Start edge: start_q registers start; start_edge = start & ~start_q. Only the edge is used, never the level.
- IDLE:
  - life = LIVES, objects_run = 0, plane_visible = 1.
  - start_edge → PLAY.
- PLAY:
  - objects_run = 1, plane_visible = 1.
  - crash is evaluated only in cycles with frame_tick = 1.
  - On frame_tick & crash: life ← life − 1.
  - If life was 1 → OVER. Otherwise → HIT and icnt ← IFRAMES.
- HIT:
  - objects_run = 1. crash is ignored entirely.
  - Each frame_tick: icnt ← icnt − 1. On a frame_tick with icnt == 1 → PLAY.
  - plane_visible = icnt[2], so the sprite blinks with a period of 8 frames.
- OVER:
  - objects_run = 0, plane_visible = 1, game_over = 1. life holds 0.
  - start_edge → PLAY, life ← LIVES, icnt ← 0.
- start_edge in PLAY or HIT is ignored.
- icnt width is $clog2(IFRAMES+1). life never underflows.

## Timing
- All outputs are registered or decoded from registered state only. crash has no combinational path to any output.
- Reset values: state IDLE, life = LIVES, icnt 0, start_q 0, objects_run 0, plane_visible 1, game_over 0, score 0.
- start_edge takes effect one cycle after the start rise. The new state is visible the next cycle.
- A crash sampled at frame_tick updates life and state on the following clock edge.
- A crash asserted only between frame_ticks is never counted.
- A 1-cycle glitch on crash counts only if it coincides with frame_tick.
- start_edge and frame_tick in the same cycle in IDLE/OVER: the transition to PLAY wins and crash is not evaluated that cycle.
- Reset mid-game returns to IDLE asynchronously. Any pending hit is discarded.
- HIT duration is exactly IFRAMES frame_ticks after entry. The first PLAY evaluation is the next frame_tick after the return to PLAY.

## Configuration
- GAME_SCORE_EN defined:
  - score port and a 16-bit counter exist.
  - The counter increments on frame_tick in PLAY and HIT and saturates at 16'hFFFF.
  - It holds in OVER and IDLE, and clears to 0 on every transition into PLAY from IDLE or OVER.
- GAME_SCORE_EN undefined: no score port and no counter; all other behaviour is identical.

## Structure
- Shared package game_pkg holds:
  - state encodings ST_IDLE/ST_PLAY/ST_HIT/ST_OVER.
  - the LIVES and IFRAMES defaults.
  - the blink bit index (2).
- Natural sub-module: game_iframe_timer. It handles icnt load/decrement on frame_tick, the expire pulse and the blink output. The FSM and lives counter stay in game_flow_ctrl.

## Test plan
- Reset then start pulse → state PLAY after 2 cycles, life 3, objects_run 1, game_over 0.
- crash held high across 3 frame_ticks in PLAY, IFRAMES=4 → life 2 after the first tick. No further decrement until 4 ticks later, then PLAY; the next crash tick gives life 1.
- Three separated hits → life 0, state OVER, objects_run 0, game_over 1. A new start edge → PLAY, life 3.
- crash pulses placed strictly between frame_ticks → life unchanged at 3.
- resetn low mid-HIT → immediate IDLE, life 3, plane_visible 1.
- With GAME_SCORE_EN: 100 frame_ticks of PLAY → score 100. Entering OVER holds 100; a restart clears the score to 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the volcano-flight game sequencer: FSM state
// encodings, default parameter values and the sprite blink bit index.
package game_pkg;

    // Top-level game FSM states; encodings are visible on the state port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } game_state_e;

    // Lives loaded at game start (legal range 1..7, fits the 3-bit life port).
    localparam int LIVES_DEF   = 3;
    // Invulnerability length in frames after a non-fatal hit.
    localparam int IFRAMES_DEF = 60;
    // Bit of the invulnerability counter that drives sprite blinking
    // (bit 2 toggles every 4 frames, giving an 8-frame blink period).
    localparam int BLINK_BIT   = 2;

endpackage : game_pkg

// File: rtl/game_iframe_timer.sv
// Post-hit invulnerability timer. Loads IFRAMES on entry to HIT, counts
// down once per qualified frame tick, pulses expire on the tick that sees
// a count of 1, and exposes the blink bit used as the plane sprite enable.
module game_iframe_timer
    import game_pkg::*;
#(
    parameter int IFRAMES = IFRAMES_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic load_i,    // start a new invulnerability window
    input  logic clear_i,   // force the counter back to 0 (game restart)
    input  logic tick_i,    // frame_tick qualified by the HIT state
    output logic expire_o,  // last frame of the window is ending
    output logic blink_o    // sprite enable while invulnerable
);

    localparam int CW = $clog2(IFRAMES + 1);

    logic [CW-1:0] icnt_q, icnt_d;

    // Next-count selection: clear beats load, load beats decrement.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        icnt_d = icnt_q;
        if (clear_i) begin
            icnt_d = '0;
        end else if (load_i) begin
            icnt_d = CW'(IFRAMES);
        end else if (tick_i && (icnt_q != '0)) begin
            icnt_d = icnt_q - CW'(1);
        end
    end

    // Counter register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its inputs.
        if (!resetn) begin
            icnt_q <= '0;
        end else begin
            icnt_q <= icnt_d;
        end
    end

    assign expire_o = tick_i && (icnt_q == CW'(1));

    // Short windows may not reach the blink bit; the sprite then stays hidden
    // for the whole window.
    generate
        if (CW > BLINK_BIT) begin : g_blink
            assign blink_o = icnt_q[BLINK_BIT];
        end else begin : g_no_blink
            assign blink_o = 1'b0;
        end
    endgenerate

endmodule : game_iframe_timer

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: reduces the per-cycle crash flag to one
// evaluation per frame, owns the lives counter, runs the post-hit
// invulnerability window and drives the movers' run enable.
// Optional feature: define GAME_SCORE_EN to add a 16-bit frames-survived
// counter on the score port.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int LIVES   = LIVES_DEF,
    parameter int IFRAMES = IFRAMES_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        crash,
    output logic [2:0]  life,
    output logic [1:0]  state,
    output logic        objects_run,
    output logic        plane_visible,
    output logic        game_over
`ifdef GAME_SCORE_EN
    ,
    output logic [15:0] score
`endif
);

    game_state_e state_q, state_d;
    logic [2:0]  life_q, life_d;
    logic        start_q;
    logic        start_edge;
    logic        iframe_load;
    logic        iframe_clear;
    logic        iframe_tick;
    logic        iframe_expire;
    logic        iframe_blink;

    assign start_edge  = start && !start_q;
    assign iframe_tick = frame_tick && (state_q == ST_HIT);

    game_iframe_timer #(
        .IFRAMES (IFRAMES)
    ) u_iframe_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load_i   (iframe_load),
        .clear_i  (iframe_clear),
        .tick_i   (iframe_tick),
        .expire_o (iframe_expire),
        .blink_o  (iframe_blink)
    );

    // Next-state and lives logic; crash is only looked at on frame ticks in PLAY.
    always_comb begin
        state_d      = state_q;
        life_d       = life_q;
        iframe_load  = 1'b0;
        iframe_clear = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                life_d = 3'(LIVES);
                if (start_edge) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (frame_tick && crash) begin
                    if (life_q <= 3'd1) begin
                        life_d  = 3'd0;
                        state_d = ST_OVER;
                    end else begin
                        life_d      = life_q - 3'd1;
                        state_d     = ST_HIT;
                        iframe_load = 1'b1;
                    end
                end
            end
            ST_HIT: begin
                if (iframe_expire) begin
                    state_d = ST_PLAY;
                end
            end
            ST_OVER: begin
                life_d = 3'd0;
                if (start_edge) begin
                    state_d      = ST_PLAY;
                    life_d       = 3'(LIVES);
                    iframe_clear = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state only, so crash never reaches a port.
    always_comb begin
        objects_run   = 1'b0;
        plane_visible = 1'b1;
        game_over     = 1'b0;
        unique case (state_q)
            ST_PLAY: objects_run = 1'b1;
            ST_HIT: begin
                objects_run   = 1'b1;
                plane_visible = iframe_blink;
            end
            ST_OVER: game_over = 1'b1;
            default: ;
        endcase
    end

    // FSM, lives and start-edge registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            life_q  <= 3'(LIVES);
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            life_q  <= life_d;
            start_q <= start;
        end
    end

    assign life  = life_q;
    assign state = state_q;

`ifdef GAME_SCORE_EN
    logic [15:0] score_q, score_d;
    logic        enter_play;

    assign enter_play = start_edge && ((state_q == ST_IDLE) || (state_q == ST_OVER));

    // Frames-survived counter: clears on a new game, saturates at all-ones.
    always_comb begin
        score_d = score_q;
        if (enter_play) begin
            score_d = '0;
        end else if (frame_tick && ((state_q == ST_PLAY) || (state_q == ST_HIT))
                     && (score_q != 16'hFFFF)) begin
            score_d = score_q + 16'd1;
        end
    end

    // Score register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;
`endif

endmodule : game_flow_ctrl
